// File: rtl/pipe_decode_pkg.sv
// pipe_decode_pkg: definitions shared by the LEGv8 pipelined decode stage.
//   - datapath geometry (WORD, INSTR_LEN, NUM_REGS, REG_BITS, XZR index)
//   - opcode constants and ALUOp encodings
//   - instruction classes, the control bundle, and the opcode classifier
package pipe_decode_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_BITS  = 5;

    localparam logic [REG_BITS-1:0] XZR = REG_BITS'(NUM_REGS - 1);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    // CBZ and B only fix a prefix of the opcode field; the rest is immediate.
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_e;

    typedef enum logic [2:0] {
        CLS_LDUR,
        CLS_STUR,
        CLS_RTYPE,
        CLS_CBZ,
        CLS_B,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic   reg2loc;
        logic   branch;
        logic   uncond_branch;
        logic   mem_read;
        logic   mem_to_reg;
        logic   mem_write;
        logic   alu_src;
        logic   reg_write;
        aluop_e alu_op;
        logic   illegal;
    } ctrl_t;

    function automatic instr_class_e classify(input logic [10:0] opcode);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        if (opcode == OP_LDUR)
            cls = CLS_LDUR;
        else if (opcode == OP_STUR)
            cls = CLS_STUR;
        else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR)
            cls = CLS_RTYPE;
        else if (opcode[10:3] == OP_CBZ_PFX)
            cls = CLS_CBZ;
        else if (opcode[10:5] == OP_B_PFX)
            cls = CLS_B;
        return cls;
    endfunction

endpackage

// File: rtl/pipe_decode_if.sv
// pipe_decode_if: bus between the fetch/writeback side and the decode stage.
//   fetch -> decode : if_valid, Instruction, nPC, flush
//   wb    -> decode : wb_RegWrite, wb_Write_register, Write_data
//   decode -> fetch : stall
//   decode -> ex    : ex_* (ID/EX pipeline register contents)
// master = fetch/writeback/execute environment, slave = pipe_decode.
interface pipe_decode_if #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int REG_BITS  = 5
);
    logic                 if_valid;
    logic [INSTR_LEN-1:0] Instruction;
    logic [WORD-1:0]      nPC;
    logic                 flush;
    logic                 wb_RegWrite;
    logic [REG_BITS-1:0]  wb_Write_register;
    logic [WORD-1:0]      Write_data;

    logic                 stall;
    logic                 ex_valid;
    logic [WORD-1:0]      ex_nPC;
    logic [WORD-1:0]      ex_Read_data1;
    logic [WORD-1:0]      ex_Read_data2;
    logic [WORD-1:0]      ex_SignExtendedOutput;
    logic [REG_BITS-1:0]  ex_Rn_num;
    logic [REG_BITS-1:0]  ex_Rm_num;
    logic [REG_BITS-1:0]  ex_Rd_num;
    logic [10:0]          ex_Opcode;
    logic                 ex_Reg2Loc;
    logic                 ex_Branch;
    logic                 ex_UncondBranch;
    logic                 ex_MemRead;
    logic                 ex_MemtoReg;
    logic                 ex_MemWrite;
    logic                 ex_ALUSrc;
    logic                 ex_RegWrite;
    logic [1:0]           ex_ALUOp;
    logic                 ex_illegal;

    modport master (
        output if_valid, Instruction, nPC, flush,
               wb_RegWrite, wb_Write_register, Write_data,
        input  stall, ex_valid, ex_nPC, ex_Read_data1, ex_Read_data2,
               ex_SignExtendedOutput, ex_Rn_num, ex_Rm_num, ex_Rd_num,
               ex_Opcode, ex_Reg2Loc, ex_Branch, ex_UncondBranch,
               ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
               ex_RegWrite, ex_ALUOp, ex_illegal
    );

    modport slave (
        input  if_valid, Instruction, nPC, flush,
               wb_RegWrite, wb_Write_register, Write_data,
        output stall, ex_valid, ex_nPC, ex_Read_data1, ex_Read_data2,
               ex_SignExtendedOutput, ex_Rn_num, ex_Rm_num, ex_Rd_num,
               ex_Opcode, ex_Reg2Loc, ex_Branch, ex_UncondBranch,
               ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
               ex_RegWrite, ex_ALUOp, ex_illegal
    );

endinterface

// File: rtl/pipe_decode_regfile_bypass.sv
// regfile_bypass: NUM_REGS x WORD register file, two combinational read
// ports, one write port committed on the rising edge.
//   clk, reset                    : clock, async active-high clear
//   read_register1/2, read_data1/2 : read ports (write-first bypass)
//   reg_write, write_register, write_data : write port
// The top index (XZR) and any index >= NUM_REGS read as zero and are never
// written.
module regfile_bypass #(
    parameter int WORD     = 64,
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] read_register1,
    input  logic [REG_BITS-1:0] read_register2,
    output logic [WORD-1:0]     read_data1,
    output logic [WORD-1:0]     read_data2,
    input  logic                reg_write,
    input  logic [REG_BITS-1:0] write_register,
    input  logic [WORD-1:0]     write_data
);

    localparam logic [REG_BITS-1:0] XZR_IDX = REG_BITS'(NUM_REGS - 1);

    logic [WORD-1:0] regs_q [NUM_REGS];
    logic [WORD-1:0] regs_d [NUM_REGS];
    logic            write_en;

    // Anything at or above XZR is not backed by storage, so it is never written.
    assign write_en = reg_write && (write_register < XZR_IDX);

    always_comb begin
        regs_d = regs_q;
        if (write_en)
            regs_d[write_register] = write_data;
    end

    // Write-first: a same-cycle write to the index being read is forwarded.
    always_comb begin
        read_data1 = '0;
        if (read_register1 < XZR_IDX)
            read_data1 = (write_en && write_register == read_register1)
                         ? write_data : regs_q[read_register1];
    end

    always_comb begin
        read_data2 = '0;
        if (read_register2 < XZR_IDX)
            read_data2 = (write_en && write_register == read_register2)
                         ? write_data : regs_q[read_register2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: pipelined LEGv8 decode stage.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : pipe_decode_if.slave
//                in : if_valid, Instruction, nPC, flush, wb_* / Write_data
//                out: stall (combinational), ex_* (registered ID/EX slot)
// Decodes controls and immediates, reads the register file, detects
// load-use hazards and fills the ID/EX register, inserting a bubble on
// flush, stall or an empty fetch slot.
module pipe_decode #(
    parameter int WORD      = pipe_decode_pkg::WORD,
    parameter int NUM_REGS  = pipe_decode_pkg::NUM_REGS,
    parameter int INSTR_LEN = pipe_decode_pkg::INSTR_LEN,
    parameter int REG_BITS  = pipe_decode_pkg::REG_BITS
) (
    input logic           clk,
    input logic           reset,
    pipe_decode_if.slave  bus
);

    import pipe_decode_pkg::*;

    localparam logic [REG_BITS-1:0] XZR_IDX = REG_BITS'(NUM_REGS - 1);

    typedef struct packed {
        logic                valid;
        logic [WORD-1:0]     npc;
        logic [WORD-1:0]     read_data1;
        logic [WORD-1:0]     read_data2;
        logic [WORD-1:0]     imm;
        logic [REG_BITS-1:0] rn;
        logic [REG_BITS-1:0] rm;
        logic [REG_BITS-1:0] rd;
        logic [10:0]         opcode;
        ctrl_t               ctrl;
    } idex_t;

    logic [10:0]         opcode;
    instr_class_e        instr_class;
    ctrl_t               ctrl;
    logic [REG_BITS-1:0] rn_num;
    logic [REG_BITS-1:0] rm_num;
    logic [REG_BITS-1:0] rd_num;
    logic [REG_BITS-1:0] read_register2;
    logic [WORD-1:0]     read_data1;
    logic [WORD-1:0]     read_data2;
    logic [WORD-1:0]     sign_ext;
    logic                uses_r2;
    logic                stall_int;
    idex_t               ex_d;
    idex_t               ex_q;

    assign opcode         = bus.Instruction[31:21];
    assign instr_class    = classify(opcode);
    assign rn_num         = bus.Instruction[9:5];
    assign rm_num         = bus.Instruction[20:16];
    assign rd_num         = bus.Instruction[4:0];
    assign read_register2 = ctrl.reg2loc ? rd_num : rm_num;
    assign uses_r2        = (instr_class == CLS_RTYPE) ||
                            (instr_class == CLS_STUR)  ||
                            (instr_class == CLS_CBZ);

    always_comb begin
        ctrl = '0;
        case (instr_class)
            CLS_LDUR: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
            end
            CLS_STUR: begin
                ctrl.reg2loc   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
            end
            CLS_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            CLS_CBZ: begin
                ctrl.reg2loc = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALUOP_BRANCH;
            end
            CLS_B: begin
                ctrl.uncond_branch = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Immediate field position depends on the format; R-type and unknown
    // opcodes carry no immediate.
    always_comb begin
        sign_ext = '0;
        case (instr_class)
            CLS_LDUR, CLS_STUR:
                sign_ext = {{(WORD-9){bus.Instruction[20]}}, bus.Instruction[20:12]};
            CLS_CBZ:
                sign_ext = {{(WORD-19){bus.Instruction[23]}}, bus.Instruction[23:5]};
            CLS_B:
                sign_ext = {{(WORD-26){bus.Instruction[25]}}, bus.Instruction[25:0]};
            default:
                sign_ext = '0;
        endcase
    end

    regfile_bypass #(
        .WORD     (WORD),
        .NUM_REGS (NUM_REGS),
        .REG_BITS (REG_BITS)
    ) u_regfile (
        .clk            (clk),
        .reset          (reset),
        .read_register1 (rn_num),
        .read_register2 (read_register2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .reg_write      (bus.wb_RegWrite),
        .write_register (bus.wb_Write_register),
        .write_data     (bus.Write_data)
    );

    // A load in EX whose destination is a source here cannot be forwarded in
    // time; XZR is exempt because it always reads zero anyway.
    assign stall_int = bus.if_valid & ex_q.valid & ex_q.ctrl.mem_read &
                       (ex_q.rd != XZR_IDX) &
                       ((rn_num == ex_q.rd) |
                        (uses_r2 & (read_register2 == ex_q.rd)));

    // Flush, stall and an empty slot all produce an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (!bus.flush && !stall_int && bus.if_valid) begin
            ex_d.valid      = 1'b1;
            ex_d.npc        = bus.nPC;
            ex_d.read_data1 = read_data1;
            ex_d.read_data2 = read_data2;
            ex_d.imm        = sign_ext;
            ex_d.rn         = rn_num;
            ex_d.rm         = rm_num;
            ex_d.rd         = rd_num;
            ex_d.opcode     = opcode;
            ex_d.ctrl       = ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.stall                 = stall_int;
    assign bus.ex_valid              = ex_q.valid;
    assign bus.ex_nPC                = ex_q.npc;
    assign bus.ex_Read_data1         = ex_q.read_data1;
    assign bus.ex_Read_data2         = ex_q.read_data2;
    assign bus.ex_SignExtendedOutput = ex_q.imm;
    assign bus.ex_Rn_num             = ex_q.rn;
    assign bus.ex_Rm_num             = ex_q.rm;
    assign bus.ex_Rd_num             = ex_q.rd;
    assign bus.ex_Opcode             = ex_q.opcode;
    assign bus.ex_Reg2Loc            = ex_q.ctrl.reg2loc;
    assign bus.ex_Branch             = ex_q.ctrl.branch;
    assign bus.ex_UncondBranch       = ex_q.ctrl.uncond_branch;
    assign bus.ex_MemRead            = ex_q.ctrl.mem_read;
    assign bus.ex_MemtoReg           = ex_q.ctrl.mem_to_reg;
    assign bus.ex_MemWrite           = ex_q.ctrl.mem_write;
    assign bus.ex_ALUSrc             = ex_q.ctrl.alu_src;
    assign bus.ex_RegWrite           = ex_q.ctrl.reg_write;
    assign bus.ex_ALUOp              = ex_q.ctrl.alu_op;
    assign bus.ex_illegal            = ex_q.ctrl.illegal;

endmodule
